// File: rtl/byte_ring_buffer.sv
// Circular word buffer with two read modes: FIFO reads consume entries,
// loop reads replay the stored contents in order without consuming them.
module byte_ring_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  // Handshake: wr_en/rd_en are requests sampled on every rising edge with no
  // ready back-pressure. A write is taken when !full, a read when !empty;
  // refused requests are dropped and only leave a sticky overflow/underflow.
  // An accepted read is answered by rd_data with a one-cycle rd_valid pulse
  // on the same edge that samples rd_en.

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] play_off;
  logic [CNT_W-1:0]  cnt;
  logic              mode_q;

  logic              is_full;
  logic              is_empty;
  logic              mode_chg;
  logic [ADDR_W-1:0] play_cur;
  logic [ADDR_W-1:0] play_next;
  logic              play_last;
  logic [ADDR_W:0]   loop_sum;
  logic [ADDR_W-1:0] loop_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_acc;
  logic              rd_acc;
  logic              fifo_rd;
  logic              loop_rd;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
  endfunction

  always_comb begin
    is_full   = (cnt == FULL_CNT);
    is_empty  = (cnt == '0);
    mode_chg  = (mode != mode_q);
    // A mode change restarts the replay at the oldest entry in the same cycle.
    play_cur  = mode_chg ? '0 : play_off;
    play_last = (CNT_W'(play_cur) == cnt - CNT_W'(1));
    play_next = play_last ? '0 : play_cur + ADDR_W'(1);
    loop_sum  = {1'b0, rd_ptr} + {1'b0, play_cur};
    loop_addr = (loop_sum >= DEPTH_X) ? ADDR_W'(loop_sum - DEPTH_X)
                                      : ADDR_W'(loop_sum);
    rd_addr   = mode ? loop_addr : rd_ptr;
    wr_acc    = wr_en && !is_full && !clear;
    rd_acc    = rd_en && !is_empty && !clear;
    fifo_rd   = rd_acc && !mode;
    loop_rd   = rd_acc && mode;
  end

  // Storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      play_off  <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      mode_q   <= mode;
      rd_valid <= rd_acc;
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        play_off  <= '0;
        cnt       <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en && is_full) begin
          overflow <= 1'b1;
        end
        if (rd_en && is_empty) begin
          underflow <= 1'b1;
        end
        if (wr_acc) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (fifo_rd) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (loop_rd) begin
          play_off <= play_next;
        end else if (mode_chg) begin
          play_off <= '0;
        end
        if (rd_acc) begin
          rd_data <= mem[rd_addr];
        end
        case ({wr_acc, fifo_rd})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign full  = is_full;
  assign empty = is_empty;
  assign count = cnt;

endmodule

// File: tb/tb_byte_ring_buffer.sv
// Bench for byte_ring_buffer: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based reference model.
module tb_byte_ring_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 10;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              mode;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  byte_ring_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Reference model: stored words oldest first, replay offset into that list
  logic [DATA_W-1:0] exp_q[$];
  int                m_off;
  logic              m_mode_prev;
  logic              m_ovf;
  logic              m_unf;
  logic              m_valid;
  logic [DATA_W-1:0] m_rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] loop_exp [7] = '{8'hA1, 8'hA2, 8'hA3, 8'hA1, 8'hA2, 8'hA3, 8'hA1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic md,
                            input logic we, input logic [DATA_W-1:0] wd, input logic re);
    bit was_full;
    bit was_empty;
    if (r) begin
      exp_q.delete();
      m_off = 0; m_ovf = 0; m_unf = 0; m_rd = '0; m_valid = 0; m_mode_prev = 0;
      return;
    end
    m_valid = 0;
    if (md != m_mode_prev) m_off = 0;
    m_mode_prev = md;
    if (c) begin
      exp_q.delete();
      m_off = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (we && was_full) m_ovf = 1;
    if (re && was_empty) m_unf = 1;
    if (re && !was_empty) begin
      m_valid = 1;
      if (!md) begin
        m_rd = exp_q.pop_front();
      end else begin
        m_rd  = exp_q[m_off];
        m_off = (m_off + 1) % exp_q.size();
      end
    end
    if (we && !was_full) exp_q.push_back(wd);
  endtask

  task automatic compare_all();
    check_eq("rd_valid", rd_valid, m_valid);
    check_eq("rd_data", rd_data, m_rd);
    check_eq("count", count, exp_q.size());
    check_eq("full", full, exp_q.size() == DEPTH);
    check_eq("empty", empty, exp_q.size() == 0);
    check_eq("overflow", overflow, m_ovf);
    check_eq("underflow", underflow, m_unf);
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic cycle(input logic r, input logic c, input logic md,
                       input logic we, input logic [DATA_W-1:0] wd, input logic re);
    @(negedge clk);
    rst = r; clear = c; mode = md; wr_en = we; wr_data = wd; rd_en = re;
    model_step(r, c, md, we, wd, re);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic cur_mode;
    rst = 1'b1; clear = 1'b0; mode = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 0, 8'h00, 0);
    check_eq("reset_count", count, 0);
    check_eq("reset_empty", empty, 1);
    check_eq("reset_rd_data", rd_data, 0);

    // Fill to full, then one dropped write
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 8'h11 + 8'(i), 0);
    check_eq("fill_full", full, 1);
    check_eq("fill_count", count, 10);
    cycle(0, 0, 0, 1, 8'hFF, 0);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_count", count, 10);

    // FIFO drain in order, then a read while empty
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 8'h00, 1);
      check_eq("drain_data", rd_data, 8'h11 + 8'(i));
      check_eq("drain_valid", rd_valid, 1);
    end
    check_eq("drain_empty", empty, 1);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check_eq("unf_flag", underflow, 1);
    check_eq("unf_valid", rd_valid, 0);
    check_eq("unf_hold", rd_data, 8'h1A);

    // Pointer wrap-around
    cycle(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 8'h20 + 8'(i), 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 8'h00, 1);
      check_eq("wrap_a", rd_data, 8'h20 + 8'(i));
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 8'h30 + 8'(i), 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 8'h00, 1);
      check_eq("wrap_b", rd_data, 8'h30 + 8'(i));
    end
    check_eq("wrap_count", count, 0);

    // Loop replay, then back to FIFO
    cycle(0, 0, 0, 1, 8'hA1, 0);
    cycle(0, 0, 0, 1, 8'hA2, 0);
    cycle(0, 0, 0, 1, 8'hA3, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 1, 0, 8'h00, 1);
      check_eq("loop_data", rd_data, loop_exp[i]);
    end
    check_eq("loop_count", count, 3);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check_eq("loop_exit", rd_data, 8'hA1);

    // Simultaneous read and write at steady occupancy
    cycle(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)), 1);
    check_eq("rw_count", count, 5);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 1, 8'h5A, 1);
    check_eq("empty_rw_count", count, 1);
    check_eq("empty_rw_unf", underflow, 1);
    check_eq("empty_rw_valid", rd_valid, 0);

    // clear mid-stream, then rst together with clear
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'h60 + 8'(i), 0);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check_eq("pre_clear_count", count, 4);
    check_eq("pre_clear_data", rd_data, 8'h5A);
    cycle(0, 1, 0, 1, 8'h77, 1);
    check_eq("clear_count", count, 0);
    check_eq("clear_empty", empty, 1);
    check_eq("clear_unf", underflow, 0);
    check_eq("clear_hold", rd_data, 8'h5A);
    cycle(1, 1, 0, 0, 8'h00, 0);
    check_eq("rst_clear_data", rd_data, 0);

    // Randomized traffic with occasional mode flips, clears and resets
    cur_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) == 0), cur_mode,
            ($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 50));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
